turn_sequencer: RTL and testbench
=================================

TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, clock cycles per one-second tick.
REQ-002 Parameter TURN_SECS, default 10, per-turn time limit in seconds (legal range 1..15).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 enable_board  input  1  level, high while game is running (from start stage).
REQ-006 p_active  input  4  player-present mask, bit i = player i+1.
REQ-007 move_valid  input  1  one-cycle pulse: current player completed a legal move.
REQ-008 game_over  input  1  one-cycle pulse from board: winner found.
REQ-009 turn_onehot  output  4  one-hot current player; 0 when no turn active.
REQ-010 turn_idx  output  2  binary index of current player.
REQ-011 turn_timer  output  4  seconds remaining in current turn.
REQ-012 timeout_pulse  output  1  one-cycle pulse when a turn expires.
REQ-013 game_active  output  1  high in TURN state.
REQ-014 round_count  output  8  completed rounds, saturating.
REQ-015 no_players  output  1  high while enable_board=1 with captured mask zero.

Function
REQ-016 FSM states SHALL be IDLE, TURN, DONE.
REQ-017 IDLE: on enable_board=1, capture p_active into mask register; if mask nonzero go TURN with lowest set bit as current player; if zero stay IDLE with no_players=1.
REQ-018 mask register SHALL be frozen for the whole game; p_active changes in TURN/DONE are ignored.
REQ-019 Turn entry SHALL load turn_timer=TURN_SECS and clear the second prescaler.
REQ-020 Prescaler SHALL count 0..CLK_HZ-1 in TURN; tick on terminal count decrements turn_timer.
REQ-021 Tick while turn_timer=1 SHALL assert timeout_pulse that cycle and advance the turn at the same edge.
REQ-022 move_valid in TURN SHALL advance the turn at the next edge (1-cycle latency to turn_onehot).
REQ-023 Advance SHALL select next set mask bit above current index, wrapping 3->0; single-player mask reselects same player and reloads timer.
REQ-024 round_count SHALL increment when the selected next index is <= current index (wrap), saturating at 255.
REQ-025 move_valid and timeout tick in the same cycle: treat as move; timeout_pulse SHALL NOT assert; one advance only.
REQ-026 game_over in TURN SHALL go DONE next edge, overriding move_valid/timeout same cycle; turn_onehot/turn_idx hold the winner's values, timer frozen.
REQ-027 enable_board=0 in any state SHALL return to IDLE next edge, clearing turn_onehot, turn_timer, round_count; highest priority after reset.
REQ-028 DONE SHALL persist until enable_board=0; move_valid/game_over ignored in IDLE and DONE.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset=0 at a clock edge SHALL force IDLE, mask=0, turn_onehot=0, turn_idx=0, turn_timer=0, timeout_pulse=0, game_active=0, round_count=0, no_players=0, prescaler=0, overriding every other input, including mid-turn.

Structure
REQ-031 Shared package turn_pkg SHALL hold the state encoding, NUM_PLAYERS=4, TIMER_W=4, ROUND_W=8.
REQ-032 Prescaler SHALL be a separate sub-module sec_tick (inputs clk, reset, clr, en; output tick), parameterised by CLK_HZ.
REQ-033 Next-player selection SHALL be a combinational function in turn_sequencer.

Verification (CLK_HZ=4, TURN_SECS=3)
REQ-034 p_active=1010, enable_board rises -> turn_onehot=0010, turn_timer=3; move_valid -> 1000; move_valid -> 0010, round_count=1.
REQ-035 p_active=0100, no moves -> timeout_pulse after 12 cycles in TURN, turn_onehot stays 0100, turn_timer reloads 3, round_count=1.
REQ-036 p_active=0000, enable_board=1 -> stays IDLE, no_players=1, game_active=0.
REQ-037 move_valid coincident with final tick -> single advance, timeout_pulse=0; game_over with move_valid -> DONE, turn_onehot unchanged.
REQ-038 reset=0 mid-turn with turn_timer=2, round_count=5 -> next edge all outputs zero, state IDLE; enable_board=0 in DONE -> IDLE.
REQ-039 255 wrap-arounds with p_active=0001 -> round_count holds 255.

Source files
------------

// File: rtl/turn_pkg.sv
// turn_pkg: shared state encoding and widths for the turn sequencer.
package turn_pkg;
  typedef enum logic [1:0] {IDLE, TURN, DONE} state_t;
  localparam int NUM_PLAYERS = 4;
  localparam int TIMER_W = 4;
  localparam int ROUND_W = 8;
endpackage

// File: rtl/sec_tick.sv
// sec_tick: one-second prescaler, pulses tick on the terminal count while enabled.
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(CLK_HZ - 1);
  always_ff @(posedge clk)
    cnt <= (!reset || clr || tick) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: rotates turns among present players with a per-turn second timer.
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TURN_SECS = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_board,
  input  logic [NUM_PLAYERS-1:0] p_active,
  input  logic                   move_valid,
  input  logic                   game_over,
  output logic [NUM_PLAYERS-1:0] turn_onehot,
  output logic [1:0]             turn_idx,
  output logic [TIMER_W-1:0]     turn_timer,
  output logic                   timeout_pulse,
  output logic                   game_active,
  output logic [ROUND_W-1:0]     round_count,
  output logic                   no_players
);
  state_t state;
  logic [NUM_PLAYERS-1:0] mask;
  logic tick, expire, adv;
  logic [1:0] nxt, first;
  // Nearest set mask bit after cur, wrapping; falls back to cur itself.
  function automatic logic [1:0] next_idx(input logic [NUM_PLAYERS-1:0] m, input logic [1:0] cur);
    next_idx = cur;
    for (int k = NUM_PLAYERS; k >= 1; k--)
      if (m[cur + 2'(k)]) next_idx = cur + 2'(k);
  endfunction
  assign first  = next_idx(p_active, 2'd3);
  assign nxt    = next_idx(mask, turn_idx);
  assign expire = tick && turn_timer == TIMER_W'(1);
  assign adv    = state == TURN && !game_over && (move_valid || expire);
  sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (state != TURN || adv),
    .en   (state == TURN),
    .tick (tick)
  );
  always_ff @(posedge clk) begin
    if (!reset || !enable_board) begin
      state         <= IDLE;
      mask          <= '0;
      turn_onehot   <= '0;
      turn_idx      <= '0;
      turn_timer    <= '0;
      timeout_pulse <= 1'b0;
      game_active   <= 1'b0;
      round_count   <= '0;
      no_players    <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          mask       <= p_active;
          no_players <= p_active == '0;
          if (p_active != '0) begin
            state       <= TURN;
            turn_idx    <= first;
            turn_onehot <= NUM_PLAYERS'(1) << first;
            turn_timer  <= TIMER_W'(TURN_SECS);
            game_active <= 1'b1;
          end
        end
        TURN: begin
          if (game_over) begin
            state       <= DONE;
            game_active <= 1'b0;
          end else if (adv) begin
            turn_idx      <= nxt;
            turn_onehot   <= NUM_PLAYERS'(1) << nxt;
            turn_timer    <= TIMER_W'(TURN_SECS);
            timeout_pulse <= !move_valid;
            round_count   <= (nxt <= turn_idx && round_count != '1) ? round_count + 1'b1 : round_count;
          end else if (tick) begin
            turn_timer <= turn_timer - 1'b1;
          end
        end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: scoreboard bench comparing the sequencer against a cycle-count reference model.
module tb_turn_sequencer;
  localparam int CH = 4;
  localparam int TS = 3;
  logic clk = 0, reset = 0, enable_board = 0, move_valid = 0, game_over = 0;
  logic [3:0] p_active = 0;
  logic [3:0] turn_onehot, turn_timer;
  logic [1:0] turn_idx;
  logic timeout_pulse, game_active, no_players;
  logic [7:0] round_count;
  typedef struct packed {
    logic [3:0] oh;
    logic [1:0] idx;
    logic [3:0] tmr;
    logic       to;
    logic       ga;
    logic [7:0] rc;
    logic       np;
  } obs_t;
  obs_t exp_q[$];
  int checks = 0, errors = 0;
  int ms = 0, mcur = 0, mel = 0, mround = 0, mfrozen = 0;
  logic [3:0] mmask = 0;
  bit mto = 0, mnp = 0;

  always #5 clk = ~clk;

  turn_sequencer #(.CLK_HZ(CH), .TURN_SECS(TS)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_board (enable_board),
    .p_active     (p_active),
    .move_valid   (move_valid),
    .game_over    (game_over),
    .turn_onehot  (turn_onehot),
    .turn_idx     (turn_idx),
    .turn_timer   (turn_timer),
    .timeout_pulse(timeout_pulse),
    .game_active  (game_active),
    .round_count  (round_count),
    .no_players   (no_players)
  );

  // Reference: ms 0=idle 1=turn 2=done; mel counts clock cycles spent in the current turn.
  task automatic model_update(input bit r, en, mv, go, input logic [3:0] p);
    int n;
    bit found;
    mto = 0;
    if (!r || !en) begin
      ms = 0; mmask = 0; mcur = 0; mel = 0; mround = 0; mnp = 0;
    end else if (ms == 0) begin
      mmask = p;
      mnp = (p == 0);
      if (p != 0) begin
        found = 0;
        for (int i = 0; i < 4; i++) if (p[i] && !found) begin mcur = i; found = 1; end
        ms = 1;
        mel = 0;
      end
    end else if (ms == 1) begin
      if (go) begin
        mfrozen = TS - mel / CH;
        ms = 2;
      end else begin
        mel++;
        if (mv || mel == TS * CH) begin
          mto = !mv;
          n = mcur;
          found = 0;
          for (int k = 1; k <= 4; k++)
            if (!found && mmask[(mcur + k) % 4]) begin n = (mcur + k) % 4; found = 1; end
          if (n <= mcur && mround < 255) mround++;
          mcur = n;
          mel = 0;
        end
      end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.oh  = ms == 0 ? 4'd0 : 4'(1 << mcur);
    o.idx = ms == 0 ? 2'd0 : 2'(mcur);
    o.tmr = ms == 1 ? 4'(TS - mel / CH) : ms == 2 ? 4'(mfrozen) : 4'd0;
    o.to  = mto;
    o.ga  = ms == 1;
    o.rc  = 8'(mround);
    o.np  = mnp;
    return o;
  endfunction

  task automatic step(input bit r, en, mv, go, input logic [3:0] p);
    reset = r; enable_board = en; move_valid = mv; game_over = go; p_active = p;
    @(posedge clk);
    #1;
    model_update(r, en, mv, go, p);
    exp_q.push_back(model_obs());
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {turn_onehot, turn_idx, turn_timer, timeout_pulse, game_active, round_count, no_players};
      checks++;
      if (a !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL outputs t=%0t actual oh=%b idx=%0d tmr=%0d to=%b ga=%b rc=%0d np=%b required oh=%b idx=%0d tmr=%0d to=%b ga=%b rc=%0d np=%b",
                   $time, a.oh, a.idx, a.tmr, a.to, a.ga, a.rc, a.np, e.oh, e.idx, e.tmr, e.to, e.ga, e.rc, e.np);
      end
    end
  end

  initial begin
    repeat (2) step(0, 0, 0, 0, 4'b0000);
    // two players, move rotation and round count
    step(1, 1, 0, 0, 4'b1010);
    step(1, 1, 1, 0, 4'b1010);
    step(1, 1, 1, 0, 4'b1010);
    repeat (3) step(1, 1, 0, 0, 4'b1010);
    step(1, 0, 0, 0, 4'b1010);
    // single player timeout; p_active changes ignored mid-game
    step(1, 1, 0, 0, 4'b0100);
    repeat (14) step(1, 1, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    // no players
    repeat (3) step(1, 1, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    // move coincident with final tick, then game_over with move
    step(1, 1, 0, 0, 4'b1010);
    repeat (11) step(1, 1, 0, 0, 4'b1010);
    step(1, 1, 1, 0, 4'b1010);
    step(1, 1, 0, 0, 4'b1010);
    step(1, 1, 1, 1, 4'b1010);
    repeat (3) step(1, 1, 1, 1, 4'b1010);
    step(1, 0, 0, 0, 4'b1010);
    // reset mid-turn with timer 2, round 5
    step(1, 1, 0, 0, 4'b0001);
    repeat (5) step(1, 1, 1, 0, 4'b0001);
    repeat (5) step(1, 1, 0, 0, 4'b0001);
    step(0, 1, 0, 0, 4'b0001);
    step(1, 1, 0, 0, 4'b0001);
    step(1, 1, 0, 1, 4'b0001);
    repeat (2) step(1, 1, 0, 0, 4'b0001);
    step(1, 0, 0, 0, 4'b0001);
    // round counter saturation
    step(1, 1, 0, 0, 4'b0001);
    repeat (260) step(1, 1, 1, 0, 4'b0001);
    repeat (13) step(1, 1, 0, 0, 4'b0001);
    step(1, 0, 0, 0, 4'b0001);
    // random traffic
    repeat (3000)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 49) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0, 4'($urandom));
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
